// File: rtl/commit_store_buffer_pkg.sv
// Shared widths, default queue depths and the store-buffer entry layout
// used by the commit store buffer and its queues.
package riscv;
    localparam int unsigned PLEN = 56;
    localparam int unsigned XLEN = 64;
endpackage

package ariane_pkg;
    localparam int unsigned DEPTH_SPEC   = 4;
    localparam int unsigned DEPTH_COMMIT = 8;

    typedef struct packed {
        logic [riscv::PLEN-1:0]   paddr;
        logic [riscv::XLEN-1:0]   data;
        logic [riscv::XLEN/8-1:0] be;
        logic [1:0]               size;
    } st_buf_entry_t;

    localparam int unsigned ST_ENTRY_W = $bits(st_buf_entry_t);
endpackage

// File: rtl/commit_store_buffer_queue.sv
// Circular store queue: one push and one pop per cycle, synchronous flush,
// plus per-entry valid/address taps for load alias checking.
module st_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              push_i,
    input  logic [ariane_pkg::ST_ENTRY_W-1:0] data_i,
    input  logic                              pop_i,
    output logic [ariane_pkg::ST_ENTRY_W-1:0] head_o,
    output logic [$clog2(DEPTH):0]            count_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic [DEPTH-1:0]                  valid_o,
    output logic [DEPTH-1:0][riscv::PLEN-1:0] paddr_o
);
    import ariane_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W:0]        cnt_q, cnt_d;
    logic [ST_ENTRY_W-1:0] mem_q [DEPTH];
    logic                  push_ok, pop_ok;
    st_buf_entry_t         tap;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rptr_q];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o;

    // Flush wins over push/pop; a popped head is still read combinationally this cycle.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        valid_o = '0;
        paddr_o = '0;
        tap     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            tap        = mem_q[i];
            paddr_o[i] = tap.paddr;
            valid_o[i] = {1'b0, PTR_W'(PTR_W'(i) - rptr_q)} < cnt_q;
        end
    end
endmodule

// File: rtl/commit_store_buffer.sv
// Store buffer holding speculative stores until commit, then draining
// committed stores to the data cache one grant at a time.
module commit_store_buffer #(
    parameter int unsigned DEPTH_SPEC   = ariane_pkg::DEPTH_SPEC,
    parameter int unsigned DEPTH_COMMIT = ariane_pkg::DEPTH_COMMIT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [riscv::PLEN-1:0]     paddr_i,
    input  logic [riscv::XLEN-1:0]     data_i,
    input  logic [riscv::XLEN/8-1:0]   be_i,
    input  logic [1:0]                 size_i,
    input  logic                       commit_i,
    output logic                       commit_ready_o,
    output logic                       no_st_pending_o,
    input  logic [11:0]                page_offset_i,
    output logic                       page_offset_matches_o,
    output logic                       req_o,
    output logic [riscv::PLEN-1:0]     addr_o,
    output logic [riscv::XLEN-1:0]     wdata_o,
    output logic [riscv::XLEN/8-1:0]   be_o,
    output logic [1:0]                 size_o,
    input  logic                       gnt_i
);
    import ariane_pkg::*;

    localparam int unsigned SPEC_CW = $clog2(DEPTH_SPEC) + 1;
    localparam int unsigned COM_CW  = $clog2(DEPTH_COMMIT) + 1;

    st_buf_entry_t                           in_entry, spec_head, com_head;
    logic [SPEC_CW-1:0]                      spec_cnt;
    logic [COM_CW-1:0]                       com_cnt;
    logic                                    spec_full, spec_empty, com_full, com_empty;
    logic [DEPTH_SPEC-1:0]                   spec_valid;
    logic [DEPTH_COMMIT-1:0]                 com_valid;
    logic [DEPTH_SPEC-1:0][riscv::PLEN-1:0]  spec_paddr;
    logic [DEPTH_COMMIT-1:0][riscv::PLEN-1:0] com_paddr;
    logic                                    spec_push, commit_ok, com_pop;
    logic                                    unused_sigs;

    assign in_entry = '{paddr: paddr_i, data: data_i, be: be_i, size: size_i};

    assign ready_o         = (spec_cnt < SPEC_CW'(DEPTH_SPEC));
    assign commit_ready_o  = (com_cnt < COM_CW'(DEPTH_COMMIT));
    assign no_st_pending_o = (com_cnt == '0);
    assign req_o           = (com_cnt != '0);

    assign spec_push = valid_i && ready_o && !flush_i;
    assign commit_ok = commit_i && !spec_empty && commit_ready_o;
    assign com_pop   = req_o && gnt_i;

    st_queue #(.DEPTH(DEPTH_SPEC)) i_spec_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (spec_push),
        .data_i  (in_entry),
        .pop_i   (commit_ok),
        .head_o  (spec_head),
        .count_o (spec_cnt),
        .full_o  (spec_full),
        .empty_o (spec_empty),
        .valid_o (spec_valid),
        .paddr_o (spec_paddr)
    );

    st_queue #(.DEPTH(DEPTH_COMMIT)) i_commit_q (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (commit_ok),
        .data_i  (spec_head),
        .pop_i   (com_pop),
        .head_o  (com_head),
        .count_o (com_cnt),
        .full_o  (com_full),
        .empty_o (com_empty),
        .valid_o (com_valid),
        .paddr_o (com_paddr)
    );

    assign addr_o  = com_head.paddr;
    assign wdata_o = com_head.data;
    assign be_o    = com_head.be;
    assign size_o  = com_head.size;

    // Doubleword-granular alias check against every live store in either queue.
    always_comb begin
        page_offset_matches_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH_SPEC; i++) begin
            if (spec_valid[i] && spec_paddr[i][11:3] == page_offset_i[11:3])
                page_offset_matches_o = 1'b1;
        end
        for (int unsigned i = 0; i < DEPTH_COMMIT; i++) begin
            if (com_valid[i] && com_paddr[i][11:3] == page_offset_i[11:3])
                page_offset_matches_o = 1'b1;
        end
    end

    assign unused_sigs = ^{page_offset_i[2:0], spec_full, com_full, com_empty,
                           spec_paddr, com_paddr};

`ifndef SYNTHESIS
    commit_legal_a: assert property (@(posedge clk_i) disable iff (rst_i)
        commit_i |-> (!spec_empty && commit_ready_o));
`endif
endmodule

// File: tb/tb_commit_store_buffer.sv
// Self-checking bench for commit_store_buffer: queue-model scoreboard plus
// directed scenarios for full/flush/stall/alias/reset corner cases.
module tb_commit_store_buffer;
    import ariane_pkg::*;

    localparam int unsigned DS = 4;
    localparam int unsigned DC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, valid, ready, commit, commit_ready, nsp, pom, req, gnt;
    logic [55:0] paddr, addr;
    logic [63:0] data, wdata;
    logic [7:0]  be, be_out;
    logic [1:0]  size, size_out;
    logic [11:0] po;

    always #5 clk = ~clk;

    commit_store_buffer #(.DEPTH_SPEC(DS), .DEPTH_COMMIT(DC)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .flush_i               (flush),
        .valid_i               (valid),
        .ready_o               (ready),
        .paddr_i               (paddr),
        .data_i                (data),
        .be_i                  (be),
        .size_i                (size),
        .commit_i              (commit),
        .commit_ready_o        (commit_ready),
        .no_st_pending_o       (nsp),
        .page_offset_i         (po),
        .page_offset_matches_o (pom),
        .req_o                 (req),
        .addr_o                (addr),
        .wdata_o               (wdata),
        .be_o                  (be_out),
        .size_o                (size_out),
        .gnt_i                 (gnt)
    );

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    int unsigned   cyc      = 0;
    st_buf_entry_t spec_m[$];
    st_buf_entry_t com_m[$];
    logic [55:0]   issued_addr[$];
    int unsigned   issued_cyc[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic alias_hit(input logic [11:0] off);
        foreach (spec_m[i]) if (spec_m[i].paddr[11:3] == off[11:3]) return 1'b1;
        foreach (com_m[i])  if (com_m[i].paddr[11:3] == off[11:3]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        valid = 0; commit = 0; flush = 0; gnt = 0;
    endtask

    task automatic set_store(input logic [55:0] a, input logic [63:0] d,
                             input logic [7:0] b, input logic [1:0] s);
        paddr = a; data = d; be = b; size = s;
    endtask

    // Inputs are set just after a falling edge; outputs are checked 1ns later.
    task automatic run_cycle();
        logic          do_push, do_commit, do_pop;
        st_buf_entry_t cur;
        #1;
        check_eq("ready_o", ready, spec_m.size() < DS);
        check_eq("commit_ready_o", commit_ready, com_m.size() < DC);
        check_eq("no_st_pending_o", nsp, com_m.size() == 0);
        check_eq("req_o", req, com_m.size() != 0);
        check_eq("page_offset_matches_o", pom, alias_hit(po));
        if (com_m.size() != 0) begin
            check_eq("addr_o", addr, com_m[0].paddr);
            check_eq("wdata_o", wdata, com_m[0].data);
            check_eq("be_o", be_out, com_m[0].be);
            check_eq("size_o", size_out, com_m[0].size);
        end
        do_push   = valid && (spec_m.size() < DS) && !flush;
        do_commit = commit && (spec_m.size() != 0) && (com_m.size() < DC);
        do_pop    = gnt && (com_m.size() != 0);
        if (do_pop) begin
            issued_addr.push_back(addr);
            issued_cyc.push_back(cyc);
        end
        cur = '{paddr: paddr, data: data, be: be, size: size};
        @(posedge clk);
        if (do_pop)    void'(com_m.pop_front());
        if (do_commit) com_m.push_back(spec_m.pop_front());
        if (flush)     spec_m.delete();
        if (do_push)   spec_m.push_back(cur);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int unsigned n);
        idle(); gnt = 1;
        for (int unsigned k = 0; k < n; k++) run_cycle();
        flush = 1; gnt = 0;
        run_cycle();
        idle();
    endtask

    initial begin
        int unsigned base;
        logic [55:0] held;
        logic [63:0] r;

        rst = 1; idle(); po = '0;
        set_store('0, '0, '0, '0);
        #1;
        check_eq("reset ready_o", ready, 1);
        check_eq("reset commit_ready_o", commit_ready, 1);
        check_eq("reset no_st_pending_o", nsp, 1);
        check_eq("reset req_o", req, 0);
        check_eq("reset page_offset_matches_o", pom, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // Three stores, two commits with grant held high.
        for (int unsigned i = 0; i < 3; i++) begin
            set_store(56'h1000 + 56'(8 * i), 64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF, 2'd3);
            valid = 1;
            run_cycle();
        end
        idle(); commit = 1; gnt = 1;
        run_cycle(); run_cycle();
        commit = 0;
        for (int unsigned k = 0; k < 3; k++) run_cycle();
        check_eq("basic issue count", issued_addr.size(), 2);
        check_eq("basic first addr", issued_addr[0], 56'h1000);
        check_eq("basic second addr", issued_addr[1], 56'h1008);
        check_eq("basic back-to-back", issued_cyc[1] - issued_cyc[0], 1);
        check_eq("basic no_st_pending_o", nsp, 1);
        check_eq("basic ready_o one left", ready, 1);
        drain(0);

        // Fill speculative queue; fifth store is refused.
        for (int unsigned i = 0; i < 5; i++) begin
            set_store(56'h3000 + 56'(8 * i), {$urandom, $urandom}, 8'h0F, 2'd2);
            valid = 1;
            run_cycle();
        end
        #1 check_eq("full ready_o", ready, 0);
        idle(); commit = 1;
        run_cycle();
        commit = 0;
        #1 check_eq("ready after commit", ready, 1);
        base = issued_addr.size();
        drain(4);
        check_eq("full drained one", issued_addr.size() - base, 1);
        check_eq("full drained addr", issued_addr[base], 56'h3000);

        // Flush coinciding with commit keeps only the committed entry.
        for (int unsigned i = 0; i < 2; i++) begin
            set_store(56'h4000 + 56'(8 * i), {$urandom, $urandom}, 8'hF0, 2'd1);
            valid = 1;
            run_cycle();
        end
        idle(); flush = 1; commit = 1;
        run_cycle();
        idle();
        #1 check_eq("flush+commit ready_o", ready, 1);
        base = issued_addr.size();
        drain(4);
        check_eq("flush+commit drained one", issued_addr.size() - base, 1);
        check_eq("flush+commit addr", issued_addr[base], 56'h4000);

        // Fill the committed queue with the grant low, then release one slot.
        set_store(56'h5000, {$urandom, $urandom}, 8'h33, 2'd0);
        valid = 1;
        run_cycle();
        for (int unsigned i = 0; i < 8; i++) begin
            set_store(56'h5008 + 56'(8 * i), {$urandom, $urandom}, 8'h33, 2'd0);
            valid = (i < 7); commit = 1;
            run_cycle();
        end
        idle();
        #1 check_eq("stall commit_ready_o", commit_ready, 0);
        held = addr;
        for (int unsigned k = 0; k < 3; k++) run_cycle();
        check_eq("stall addr held", addr, held);
        check_eq("stall req held", req, 1);
        gnt = 1;
        run_cycle();
        gnt = 0;
        #1 check_eq("stall commit_ready after grant", commit_ready, 1);
        drain(9);

        // Load alias check at doubleword granularity.
        set_store(56'h2A38, 64'h1234, 8'hFF, 2'd3);
        valid = 1;
        run_cycle();
        idle(); po = 12'hA3C;
        #1 check_eq("alias hit", pom, 1);
        po = 12'hA40;
        #1 check_eq("alias miss", pom, 0);
        run_cycle();
        drain(0);

        // Random mix of pushes, commits, flushes and grants.
        for (int unsigned k = 0; k < 300; k++) begin
            r = {$urandom, $urandom};
            r[11:3] = 9'($urandom_range(0, 15));
            set_store(r[55:0], {$urandom, $urandom}, 8'($urandom), 2'($urandom));
            valid  = ($urandom_range(0, 3) != 0);
            commit = ($urandom_range(0, 1) == 1) && (spec_m.size() != 0) && (com_m.size() < DC);
            flush  = ($urandom_range(0, 15) == 0);
            gnt    = ($urandom_range(0, 2) != 0);
            po     = {3'($urandom), 6'($urandom_range(0, 15)), 3'($urandom)};
            run_cycle();
        end
        drain(DC + 2);

        // Reset arriving mid-drain discards everything.
        for (int unsigned i = 0; i < 3; i++) begin
            set_store(56'h6000 + 56'(8 * i), {$urandom, $urandom}, 8'hFF, 2'd3);
            valid = 1;
            run_cycle();
        end
        idle(); commit = 1;
        for (int unsigned i = 0; i < 3; i++) run_cycle();
        idle();
        #1 check_eq("pre-reset req_o", req, 1);
        rst = 1;
        #1;
        check_eq("mid-drain reset req_o", req, 0);
        check_eq("mid-drain reset no_st_pending_o", nsp, 1);
        spec_m.delete();
        com_m.delete();
        gnt = 1;
        @(negedge clk);
        rst = 0;
        base = issued_addr.size();
        for (int unsigned k = 0; k < 4; k++) run_cycle();
        check_eq("post-reset no grants", issued_addr.size() - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/commit_store_buffer.md
COMMIT_STORE_BUFFER -- requirements
Module: commit_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH_SPEC, default 4, speculative store queue depth, power of two and at least 2.
REQ-002 SHALL have parameter DEPTH_COMMIT, default 8, committed store queue depth, power of two and at least 2.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have these ports (name, direction, width, meaning):
 - clk_i  in  1  clock, rising edge.
 - rst_i  in  1  asynchronous active-high reset.
 - flush_i  in  1  discard all speculative stores.
 - valid_i  in  1  LSU presents an executed store.
 - ready_o  out  1  speculative queue can accept.
 - paddr_i  in  riscv::PLEN  store physical address.
 - data_i  in  riscv::XLEN  store data.
 - be_i  in  riscv::XLEN/8  byte enables.
 - size_i  in  2  access size.
 - commit_i  in  1  commit stage retires the oldest store.
 - commit_ready_o  out  1  committed queue can accept.
 - no_st_pending_o  out  1  committed queue empty.
 - page_offset_i  in  12  load page offset for hazard check.
 - page_offset_matches_o  out  1  an outstanding store aliases the load.
 - req_o  out  1  D$ write request.
 - addr_o  out  riscv::PLEN  request address.
 - wdata_o  out  riscv::XLEN  request data.
 - be_o  out  riscv::XLEN/8  request byte enables.
 - size_o  out  2  request size.
 - gnt_i  in  1  D$ grant.

Function
REQ-005 SHALL set ready_o = (spec_cnt < DEPTH_SPEC), using only the registered count; a pop in the same cycle does not raise ready_o.
REQ-006 SHALL push {paddr_i, data_i, be_i, size_i} into the speculative tail on valid_i && ready_o && !flush_i.
REQ-007 SHALL, on commit_i, move the speculative head to the committed tail in the same cycle, so the entry is visible in the committed queue next cycle.
REQ-008 SHALL set commit_ready_o = (commit_cnt < DEPTH_COMMIT) from the registered count only.
REQ-009 SHALL ignore commit_i while the speculative queue is empty or !commit_ready_o, and flag this with a simulation-only assertion.
REQ-010 SHALL, on flush_i, clear the speculative pointers and count at the next edge; the committed queue is unaffected.
REQ-011 SHALL, when flush_i and commit_i occur in the same cycle, perform the commit first and then clear the remaining speculative entries.
REQ-012 SHALL drop any push that coincides with flush_i.
REQ-013 SHALL drive req_o = (commit_cnt != 0) and drive addr_o, wdata_o, be_o, size_o combinationally from the committed head.
REQ-014 SHALL hold the request fields stable while req_o && !gnt_i.
REQ-015 SHALL pop the committed head on req_o && gnt_i.
REQ-016 SHALL allow at most one pop per cycle; a store committed in cycle N reaches req_o no earlier than N+1.
REQ-017 SHALL support simultaneous push (commit) and pop (grant) on the committed queue, leaving commit_cnt unchanged; the same applies to the speculative queue with push (valid_i) and pop (commit_i).
REQ-018 SHALL wrap pointers modulo depth; counters are $clog2(DEPTH)+1 bits wide and never overflow or underflow.
REQ-019 SHALL set no_st_pending_o = (commit_cnt == 0), combinational from the registered count.
REQ-020 SHALL assert page_offset_matches_o combinationally when any valid entry in either queue has paddr[11:3] == page_offset_i[11:3].

Reset
REQ-021 SHALL, on rst_i, asynchronously zero all pointers and counts, giving ready_o=1, commit_ready_o=1, no_st_pending_o=1, req_o=0, page_offset_matches_o=0.
REQ-022 SHALL leave data arrays unreset; outputs derived from them are don't-care while req_o=0.
REQ-023 SHALL discard both queues when reset arrives mid-drain, with no further requests issued.

Structure
REQ-024 SHALL define st_buf_entry_t {paddr, data, be, size}, DEPTH_SPEC and DEPTH_COMMIT defaults in ariane_pkg.
REQ-025 SHALL implement both queues as two instances of one sub-module, st_queue: a circular buffer with push, pop, flush, count, full, empty and head outputs, plus per-entry valid and address for the alias check.
REQ-026 SHALL tie the flush input of the committed-queue instance to 0.

Verification
REQ-027 Push 3 stores (paddr 0x1000, 0x1008, 0x1010), commit 2, gnt_i=1 -> req_o issues 0x1000 then 0x1008 on consecutive cycles; spec_cnt=1; no_st_pending_o=1 afterwards.
REQ-028 Fill the speculative queue with 4 stores -> ready_o=0; a 5th valid_i is not accepted; one commit_i -> ready_o=1 the following cycle.
REQ-029 Push 2, then flush_i together with commit_i -> exactly 1 committed entry drains; spec_cnt=0 next cycle.
REQ-030 Commit 8 stores with gnt_i=0 -> commit_ready_o=0 and req_o held with unchanged fields; raise gnt_i for one cycle -> commit_ready_o=1 next cycle.
REQ-031 Outstanding store at paddr 0x2A38, page_offset_i=0xA3C -> page_offset_matches_o=1; page_offset_i=0xA40 -> 0.
REQ-032 Assert rst_i with 3 committed stores while req_o=1 -> req_o=0 and no_st_pending_o=1 immediately, with no further grants consumed.
